loop_nest_counter: RTL and testbench
====================================

// Module: loop_nest_counter
// PURPOSE
//  Parametrised 3-level nested loop counter (x innermost, then y, then c), successor to the 4-bit enable counter.
//  Generates (x,y,c) index tuples for conv window / feature-map addressing in the CNN datapath.
//  Runtime-programmable limits, start/busy/done handshake, enable-based stall, per-level wrap flags.
// PARAMETERS
//  W_X  4  width of x counter and limit_x
//  W_Y  4  width of y counter and limit_y
//  W_C  4  width of c counter and limit_c
// PORTS
//  clk      in   1    rising-edge clock
//  rst_n    in   1    async active-low reset
//  start    in   1    start request; accepted only when busy==0
//  enable   in   1    advance one tuple this cycle (stall when 0)
//  limit_x  in   W_X  last x value (inclusive); sampled on accepted start
//  limit_y  in   W_Y  last y value (inclusive); sampled on accepted start
//  limit_c  in   W_C  last c value (inclusive); sampled on accepted start
//  cnt_x    out  W_X  current x index (registered)
//  cnt_y    out  W_Y  current y index (registered)
//  cnt_c    out  W_C  current c index (registered)
//  busy     out  1    high while a sweep is in progress (registered)
//  wrap_x   out  1    comb: busy & enable & cnt_x==lim_x
//  wrap_y   out  1    comb: wrap_x & cnt_y==lim_y
//  last     out  1    comb: wrap_y & cnt_c==lim_c (final tuple consumed this cycle)
//  done     out  1    registered 1-cycle pulse, cycle after last
// BEHAVIOUR
//  Reset (async, any time incl. mid-sweep): cnt_*=0, busy=0, done=0, latched limits=0; FSM->IDLE.
//  FSM: IDLE, RUN. IDLE--start-->RUN; RUN--last-->IDLE. No other transitions.
//  Accepted start (IDLE): latch limit_x/y/c, cnt_*<=0, busy<=1. First tuple (0,0,0) valid next cycle.
//  start while busy: ignored, latched limits unchanged.
//  RUN, enable=0: all registers hold; wrap_*/last low.
//  RUN, enable=1: tuple on cnt_* consumed this cycle; next values:
//   - cnt_x<lim_x: cnt_x+1.
//   - wrap_x & !wrap_y: cnt_x<=0, cnt_y+1.
//   - wrap_y & !last: cnt_x<=0, cnt_y<=0, cnt_c+1.
//   - last: cnt_*<=0, busy<=0, done<=1 next cycle, FSM->IDLE.
//  done is high exactly one cycle, in first IDLE cycle; start in that cycle is accepted (back-to-back sweeps).
//  Tuples per sweep = (lim_x+1)*(lim_y+1)*(lim_c+1) enabled RUN cycles; order x fastest, c slowest.
//  All limits 0: single tuple (0,0,0); last asserts on first enabled RUN cycle.
//  Limit = all-ones: counter reaches 2^W-1 then wraps to 0 via wrap logic; never overflows.
//  Counters are unsigned, no arithmetic overflow path; comparisons against latched limits only.
//  Input limits changing during RUN have no effect.
//  IDLE: cnt_*=0, wrap_*/last=0 regardless of enable.
// TESTING
//  T1 reset: assert rst_n=0 mid-sweep at cnt=(2,1,0) -> same-cycle cnt_*=0, busy=0, done=0; holds while rst_n=0.
//  T2 full sweep: lim=(2,1,1), start, enable=1 -> 12 tuples (0,0,0)..(2,1,1) in x-fastest order; wrap_x every 3rd, wrap_y every 6th; done 1 cycle after (2,1,1).
//  T3 stall: lim=(3,0,0), enable toggled 1,0,0,1,1,1 -> cnt_x 0,1,1,1,2,3; last with enable at cnt_x=3; done next cycle.
//  T4 degenerate: lim=(0,0,0), start, enable=1 -> one tuple (0,0,0), last same cycle, done next, busy 1 cycle only.
//  T5 start while busy: lim=(1,1,0) running, pulse start with lim=(7,7,7) -> ignored; sweep ends after 4 tuples.
//  T6 back-to-back + max: start on done cycle with W_X=4 lim_x=15 -> new sweep, cnt_x 0..15 then wrap to 0, no glitch.

Source files
------------

// File: rtl/loop_nest_counter.sv
// -----------------------------------------------------------------------------
// loop_nest_counter
//
// Three-level nested loop counter that produces (x, y, c) index tuples for
// conv-window / feature-map addressing. x is the innermost (fastest) loop and
// c the outermost. Limits are inclusive and sampled when a start is accepted.
// The sweep advances one tuple per cycle while enable is high.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    start request, accepted only when busy == 0
//   enable   in   1    consume the current tuple this cycle (stall when 0)
//   limit_x  in   W_X  last x value (inclusive), sampled on accepted start
//   limit_y  in   W_Y  last y value (inclusive), sampled on accepted start
//   limit_c  in   W_C  last c value (inclusive), sampled on accepted start
//   cnt_x    out  W_X  current x index (registered)
//   cnt_y    out  W_Y  current y index (registered)
//   cnt_c    out  W_C  current c index (registered)
//   busy     out  1    sweep in progress (registered)
//   wrap_x   out  1    x is wrapping this cycle (combinational)
//   wrap_y   out  1    y is wrapping this cycle (combinational)
//   last     out  1    final tuple consumed this cycle (combinational)
//   done     out  1    one-cycle pulse in the cycle after last (registered)
// -----------------------------------------------------------------------------
module loop_nest_counter #(
  parameter int W_X = 4,
  parameter int W_Y = 4,
  parameter int W_C = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           enable,
  input  logic [W_X-1:0] limit_x,
  input  logic [W_Y-1:0] limit_y,
  input  logic [W_C-1:0] limit_c,
  output logic [W_X-1:0] cnt_x,
  output logic [W_Y-1:0] cnt_y,
  output logic [W_C-1:0] cnt_c,
  output logic           busy,
  output logic           wrap_x,
  output logic           wrap_y,
  output logic           last,
  output logic           done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic [W_X-1:0] lim_x;
  logic [W_Y-1:0] lim_y;
  logic [W_C-1:0] lim_c;

  // Comparisons use the latched limits only, so input limits may change
  // freely during a sweep. Gating with busy keeps all flags low in IDLE,
  // where the counters sit at zero and could otherwise match a zero limit.
  assign wrap_x = busy & enable & (cnt_x == lim_x);
  assign wrap_y = wrap_x & (cnt_y == lim_y);
  assign last   = wrap_y & (cnt_c == lim_c);

  // Each counter wraps through the explicit reset-to-zero path when it hits
  // its limit, so an all-ones limit never relies on arithmetic rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt_x <= '0;
      cnt_y <= '0;
      cnt_c <= '0;
      lim_x <= '0;
      lim_y <= '0;
      lim_c <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its peers; blocking would create ordering races.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lim_x <= limit_x;
            lim_y <= limit_y;
            lim_c <= limit_c;
            cnt_x <= '0;
            cnt_y <= '0;
            cnt_c <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // start is deliberately ignored here: a sweep cannot be restarted.
          if (last) begin
            cnt_x <= '0;
            cnt_y <= '0;
            cnt_c <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (wrap_y) begin
            cnt_x <= '0;
            cnt_y <= '0;
            cnt_c <= cnt_c + 1'b1;
          end else if (wrap_x) begin
            cnt_x <= '0;
            cnt_y <= cnt_y + 1'b1;
          end else if (enable) begin
            cnt_x <= cnt_x + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_counter.sv
// -----------------------------------------------------------------------------
// tb_loop_nest_counter
//
// Directed bench for loop_nest_counter (default 4-bit widths). Inputs change
// on the falling clock edge and outputs are compared 1 ns later. When a sweep
// is started, the expected tuple sequence (with wrap/last flags) is generated
// from the limits and pushed to a scoreboard queue; each enabled cycle pops
// one entry and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_loop_nest_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       enable;
  logic [3:0] limit_x;
  logic [3:0] limit_y;
  logic [3:0] limit_c;
  logic [3:0] cnt_x;
  logic [3:0] cnt_y;
  logic [3:0] cnt_c;
  logic       busy;
  logic       wrap_x;
  logic       wrap_y;
  logic       last;
  logic       done;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] c;
    logic       wx;
    logic       wy;
    logic       lst;
  } tup_t;

  tup_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  loop_nest_counter #(.W_X(4), .W_Y(4), .W_C(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .enable  (enable),
    .limit_x (limit_x),
    .limit_y (limit_y),
    .limit_c (limit_c),
    .cnt_x   (cnt_x),
    .cnt_y   (cnt_y),
    .cnt_c   (cnt_c),
    .busy    (busy),
    .wrap_x  (wrap_x),
    .wrap_y  (wrap_y),
    .last    (last),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, passing one rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive an accepted start from IDLE and queue the expected tuples.
  task automatic do_start(input int lx, input int ly, input int lc);
    tup_t e;
    start   = 1'b1;
    enable  = 1'b0;
    limit_x = 4'(lx);
    limit_y = 4'(ly);
    limit_c = 4'(lc);
    #1;
    check("start_idle_busy", busy, 0);
    tick();
    start = 1'b0;
    for (int c = 0; c <= lc; c++)
      for (int y = 0; y <= ly; y++)
        for (int x = 0; x <= lx; x++) begin
          e.x   = 4'(x);
          e.y   = 4'(y);
          e.c   = 4'(c);
          e.wx  = (x == lx);
          e.wy  = (x == lx) && (y == ly);
          e.lst = (x == lx) && (y == ly) && (c == lc);
          sb.push_back(e);
        end
    #1;
    check("start_busy", busy, 1);
    check("start_cnt", {cnt_c, cnt_y, cnt_x}, 0);
  endtask

  // One cycle with the given enable; compares against the scoreboard head.
  task automatic run_cycle(input logic en, input string tag);
    tup_t e;
    enable = en;
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb[0];
      check({tag, "_cnt"}, {cnt_c, cnt_y, cnt_x}, {e.c, e.y, e.x});
      check({tag, "_busy"}, busy, 1);
      if (en) begin
        check({tag, "_flags"}, {wrap_x, wrap_y, last}, {e.wx, e.wy, e.lst});
        void'(sb.pop_front());
      end else begin
        check({tag, "_stall_flags"}, {wrap_x, wrap_y, last}, 3'b000);
      end
    end
    tick();
  endtask

  // Run enabled until the scoreboard drains (bounded), then check done.
  task automatic finish_sweep(input string tag);
    int budget = 5000;
    while (sb.size() > 0 && budget > 0) begin
      run_cycle(1'b1, tag);
      budget--;
    end
    check({tag, "_budget"}, (budget > 0), 1);
    #1;
    check({tag, "_done"}, {done, busy}, 2'b10);
    check({tag, "_idle_cnt"}, {cnt_c, cnt_y, cnt_x}, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    enable  = 1'b0;
    limit_x = '0;
    limit_y = '0;
    limit_c = '0;
    @(negedge clk);
    #1;
    check("reset_outputs", {cnt_c, cnt_y, cnt_x, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: reset mid-sweep at (2,1,0)
    do_start(2, 1, 1);
    for (int i = 0; i < 5; i++) run_cycle(1'b1, "t1_run");
    #1;
    check("t1_pre_reset_cnt", {cnt_c, cnt_y, cnt_x}, {4'd0, 4'd1, 4'd2});
    #1;
    rst_n  = 1'b0;
    enable = 1'b1;
    start  = 1'b1;
    #1;
    check("t1_async_reset", {cnt_c, cnt_y, cnt_x, busy, done}, 0);
    check("t1_reset_flags", {wrap_x, wrap_y, last}, 3'b000);
    @(posedge clk);
    #1;
    check("t1_reset_hold", {cnt_c, cnt_y, cnt_x, busy, done}, 0);
    @(negedge clk);
    start  = 1'b0;
    enable = 1'b0;
    rst_n  = 1'b1;
    sb.delete();
    tick();

    // T2: full sweep, limits (2,1,1); input limits disturbed mid-sweep
    do_start(2, 1, 1);
    limit_x = 4'd0;
    limit_y = 4'd0;
    limit_c = 4'd0;
    finish_sweep("t2");
    tick();
    check("t2_done_width", done, 0);

    // T3: stall pattern with limits (3,0,0)
    do_start(3, 0, 0);
    run_cycle(1'b1, "t3");
    run_cycle(1'b0, "t3");
    run_cycle(1'b0, "t3");
    run_cycle(1'b1, "t3");
    run_cycle(1'b1, "t3");
    finish_sweep("t3");
    tick();

    // T4: all limits zero, single tuple; then IDLE with enable high
    do_start(0, 0, 0);
    finish_sweep("t4");
    enable = 1'b1;
    tick();
    check("t4_idle_flags", {wrap_x, wrap_y, last, busy, done}, 5'b0);
    enable = 1'b0;

    // T5: start while busy is ignored
    do_start(1, 1, 0);
    run_cycle(1'b1, "t5");
    start   = 1'b1;
    limit_x = 4'd7;
    limit_y = 4'd7;
    limit_c = 4'd7;
    run_cycle(1'b1, "t5_start_busy");
    start = 1'b0;
    finish_sweep("t5");

    // T6: back-to-back start on the done cycle, x at all-ones limit
    do_start(15, 0, 0);
    finish_sweep("t6");
    tick();
    check("t6_done_width", {done, busy}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
